// File: rtl/asm_seq_ctrl.sv
// Instruction sequencer for the 2-register, 2-bit toy machine.
// Fetches 6-bit instructions over a req/ack port and executes one ALU op per instruction.
module asm_seq_ctrl #(
    parameter int unsigned PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [5:0]      imem_data,
    output logic [1:0]      ax,
    output logic [1:0]      bx,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      ax_q, ax_d;
    logic [1:0]      bx_q, bx_d;
    logic [5:0]      ir_q, ir_d;
    logic            illegal_q, illegal_d;

    logic [3:0] op;
    logic       reg1, reg2;
    logic [1:0] x, y, res;
    logic       wr_en, halt_op, bad_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ax_q      <= '0;
            bx_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ax_q      <= ax_d;
            bx_q      <= bx_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Decode and ALU slice for the latched instruction.
    always_comb begin
        op      = ir_q[5:2];
        reg1    = ir_q[1];
        reg2    = ir_q[0];
        x       = reg1 ? bx_q : ax_q;
        y       = reg2 ? bx_q : ax_q;
        res     = '0;
        wr_en   = 1'b0;
        halt_op = 1'b0;
        bad_op  = 1'b0;
        case (op)
            4'h0: ;
            4'h1: begin res = y;         wr_en = 1'b1; end
            4'h2: begin res = x | y;     wr_en = 1'b1; end
            4'h3: begin res = x ^ y;     wr_en = 1'b1; end
            4'h4: begin res = ~y;        wr_en = 1'b1; end
            4'h5: begin res = x + 2'd1;  wr_en = 1'b1; end
            4'h7: begin res = x & y;     wr_en = 1'b1; end
            4'hF: halt_op = 1'b1;
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ax_d      = ax_q;
        bx_d      = bx_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (halt_op || bad_op) begin
                    state_d   = S_HALT;
                    illegal_d = bad_op;
                end else begin
                    if (wr_en) begin
                        if (reg1) bx_d = res;
                        else      ax_d = res;
                    end
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                // Restart rewinds the PC but keeps the architectural registers.
                if (start) begin
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign ax        = ax_q;
    assign bx        = bx_q;
    assign pc        = pc_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_asm_seq_ctrl.sv
// Directed self-checking bench for asm_seq_ctrl: programs, wait states, illegal op, reset, PC wrap.
module tb_asm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [5:0] imem_data;
    logic [1:0] ax, bx;
    logic [3:0] pc;
    logic       busy, halted, illegal;

    logic       start2;
    logic       req2;
    logic [1:0] addr2;
    logic       ack2;
    logic [5:0] data2;
    logic [1:0] ax2, bx2;
    logic [1:0] pc2;
    logic       busy2, halted2, illegal2;

    logic [5:0] mem [16];
    int errors = 0;
    int checks = 0;
    int cyc;

    always #5 clk = ~clk;

    asm_seq_ctrl #(.PC_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .ax(ax), .bx(bx), .pc(pc),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    asm_seq_ctrl #(.PC_W(2)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_data(data2),
        .ax(ax2), .bx(bx2), .pc(pc2),
        .busy(busy2), .halted(halted2), .illegal(illegal2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 6'b111100;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Serves fetches from mem, inserting 'waits' idle cycles before each ack.
    task automatic run(input int max_cyc, input int waits, output int n);
        int wcnt;
        logic [3:0] hold;
        wcnt = 0;
        hold = '0;
        for (n = 0; n < max_cyc; n++) begin
            if (halted) break;
            if (wcnt > 0) begin
                chk("req_held", {7'd0, imem_req}, 8'd1);
                chk("addr_stable", {4'd0, imem_addr}, {4'd0, hold});
            end
            if (imem_req) begin
                if (wcnt == 0) hold = imem_addr;
                if (wcnt == waits) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    wcnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("run_halted", {7'd0, halted}, 8'd1);
    endtask

    task automatic load_and_prog();
        clear_mem();
        mem[0] = 6'b010100;  // INC AX
        mem[1] = 6'b010100;  // INC AX
        mem[2] = 6'b000110;  // MOV BX,AX
        mem[3] = 6'b010110;  // INC BX
        mem[4] = 6'b011101;  // AND AX,BX
        mem[5] = 6'b111100;  // HALT
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
        start2 = 1'b0; ack2 = 1'b1; data2 = 6'b000000;

        repeat (2) @(negedge clk);
        chk("rst_req", {7'd0, imem_req}, 8'd0);
        chk("rst_addr", {4'd0, imem_addr}, 8'd0);
        chk("rst_ax", {6'd0, ax}, 8'd0);
        chk("rst_bx", {6'd0, bx}, 8'd0);
        chk("rst_pc", {4'd0, pc}, 8'd0);
        chk("rst_flags", {5'd0, busy, halted, illegal}, 8'd0);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {6'd0, busy, imem_req}, 8'd0);
        chk("idle_pc", {4'd0, pc}, 8'd0);
        imem_ack = 1'b0;

        // AND program, zero wait states
        load_and_prog();
        kick();
        chk("start_req", {7'd0, imem_req}, 8'd1);
        chk("start_addr", {4'd0, imem_addr}, 8'd0);
        chk("start_busy", {7'd0, busy}, 8'd1);
        run(100, 0, cyc);
        chk("and_cycles", 8'(cyc), 8'd12);
        chk("and_ax", {6'd0, ax}, 8'd2);
        chk("and_bx", {6'd0, bx}, 8'd3);
        chk("and_pc", {4'd0, pc}, 8'd5);
        chk("and_flags", {5'd0, busy, halted, illegal}, 8'b010);
        chk("halt_req", {7'd0, imem_req}, 8'd0);

        // Same program with 3 wait states per fetch
        pulse_reset();
        kick();
        run(200, 3, cyc);
        chk("wait_cycles", 8'(cyc), 8'd30);
        chk("wait_ax", {6'd0, ax}, 8'd2);
        chk("wait_bx", {6'd0, bx}, 8'd3);
        chk("wait_pc", {4'd0, pc}, 8'd5);

        // Undefined opcode at pc=2
        pulse_reset();
        clear_mem();
        mem[0] = 6'b010100;
        mem[1] = 6'b010100;
        mem[2] = 6'b101000;
        kick();
        run(100, 0, cyc);
        chk("ill_cycles", 8'(cyc), 8'd6);
        chk("ill_flags", {5'd0, busy, halted, illegal}, 8'b011);
        chk("ill_pc", {4'd0, pc}, 8'd2);
        chk("ill_ax", {6'd0, ax}, 8'd2);
        chk("ill_bx", {6'd0, bx}, 8'd0);
        kick();
        chk("restart_req", {7'd0, imem_req}, 8'd1);
        chk("restart_addr", {4'd0, imem_addr}, 8'd0);
        chk("restart_flags", {5'd0, busy, halted, illegal}, 8'b100);
        chk("restart_ax_kept", {6'd0, ax}, 8'd2);

        // Async reset while a fetch is pending
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {7'd0, imem_req}, 8'd0);
        chk("async_regs", {ax, bx, pc}, 8'd0);
        chk("async_flags", {5'd0, busy, halted, illegal}, 8'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("async_idle", {6'd0, busy, imem_req}, 8'd0);

        // Mixed ALU program including reg1==reg2 cases
        clear_mem();
        mem[0] = 6'b010000;  // NOT AX,AX  -> ax=3
        mem[1] = 6'b000110;  // MOV BX,AX  -> bx=3
        mem[2] = 6'b001111;  // XOR BX,BX  -> bx=0
        mem[3] = 6'b010110;  // INC BX     -> bx=1
        mem[4] = 6'b010001;  // NOT AX,BX  -> ax=2
        mem[5] = 6'b001010;  // OR BX,AX   -> bx=3
        mem[6] = 6'b000000;  // NOP
        mem[7] = 6'b001101;  // XOR AX,BX  -> ax=1
        mem[8] = 6'b011100;  // AND AX,AX  -> ax=1
        mem[9] = 6'b111100;  // HALT
        kick();
        run(100, 0, cyc);
        chk("mix_cycles", 8'(cyc), 8'd20);
        chk("mix_ax", {6'd0, ax}, 8'd1);
        chk("mix_bx", {6'd0, bx}, 8'd3);
        chk("mix_pc", {4'd0, pc}, 8'd9);
        chk("mix_illegal", {7'd0, illegal}, 8'd0);

        // PC wrap on the 2-bit-PC instance running NOPs
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("wrap_busy", {7'd0, busy2}, 8'd1);
            if (k % 2 == 0) begin
                chk("wrap_req", {7'd0, req2}, 8'd1);
                chk("wrap_addr", {6'd0, addr2}, 8'((k / 2) % 4));
            end
            @(negedge clk);
        end
        chk("wrap_no_flag", {6'd0, halted2, illegal2}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
